key_set_ctrl: RTL and testbench

//  Front-end for the clock-setting pushbuttons; sits directly upstream of the 1-to-3 adjust demux.

---
 rtl/key_set_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_key_set_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_set_ctrl.sv
// Pushbutton front end for the clock-setting path: synchronises and debounces MODE/ADJ,
// steps the field selector on MODE and emits single-cycle ADJ strobes with hold-to-repeat.
module key_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int NUM_SET         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_n,
    input  logic       key_adj_n,
    output logic [1:0] set,
    output logic       adj_n,
    output logic       adj_pulse,
    output logic       mode_changed
);
    localparam int KEY_MODE = 0;
    localparam int KEY_ADJ  = 1;

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ARM_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int T_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 1);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);
    localparam logic [T_W-1:0]   RD_LAST  = T_W'(REPEAT_DELAY - 1);
    localparam logic [T_W-1:0]   RP_LAST  = T_W'(REPEAT_PERIOD - 1);
    localparam logic [T_W-1:0]   T_ONE    = T_W'(1);
    localparam logic [1:0]       SET_LAST = 2'(NUM_SET - 1);

    logic [1:0] w_keys_n;
    logic [1:0] w_press;
    logic       w_adj_held;

    assign w_keys_n = {key_adj_n, key_mode_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic             r_sync1;
            logic             r_sync2;
            logic             r_db;
            logic             r_db_d1;
            logic             r_press;
            logic             r_armed;
            logic [DB_W-1:0]  r_db_cnt;
            logic [ARM_W-1:0] r_arm_cnt;

            // A key is only armed once it has been seen released for a debounce period
            // after reset (plus the two stale synchroniser samples), so a key held through
            // reset must be released and pressed again before it acts.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1   <= 1'b1;
                    r_sync2   <= 1'b1;
                    r_db      <= 1'b1;
                    r_db_d1   <= 1'b1;
                    r_press   <= 1'b0;
                    r_armed   <= 1'b0;
                    r_db_cnt  <= '0;
                    r_arm_cnt <= '0;
                end else begin
                    r_sync1 <= w_keys_n[gi];
                    r_sync2 <= r_sync1;
                    r_db_d1 <= r_db;
                    r_press <= r_armed & r_db_d1 & ~r_db;
                    if (r_sync2 != r_db) begin
                        if (r_db_cnt == DB_LAST) begin
                            r_db     <= r_sync2;
                            r_db_cnt <= '0;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_ONE;
                        end
                    end else begin
                        r_db_cnt <= '0;
                    end
                    if (!r_armed) begin
                        if (!r_sync2) begin
                            r_arm_cnt <= '0;
                        end else if (r_arm_cnt == ARM_LAST) begin
                            r_armed <= 1'b1;
                        end else begin
                            r_arm_cnt <= r_arm_cnt + ARM_ONE;
                        end
                    end
                end
            end

            assign w_press[gi] = r_press;

            if (gi == KEY_ADJ) begin : g_adj
                assign w_adj_held = ~r_db;
            end
        end
    endgenerate

    logic       w_mode_press;
    logic       w_adj_press;
    logic [1:0] r_set;
    logic       r_mode_changed;

    assign w_mode_press = w_press[KEY_MODE];
    assign w_adj_press  = w_press[KEY_ADJ];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_set          <= 2'd0;
            r_mode_changed <= 1'b0;
        end else begin
            r_mode_changed <= w_mode_press;
            if (w_mode_press) begin
                r_set <= (r_set == SET_LAST) ? 2'd0 : r_set + 2'd1;
            end
        end
    end

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT, ST_LOCK} adj_state_t;

    adj_state_t     r_state;
    adj_state_t     w_state_next;
    logic [T_W-1:0] r_timer;
    logic [T_W-1:0] w_timer_next;
    logic           w_strobe;
    logic           r_adj_n;
    logic           r_adj_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_adj_n     <= 1'b1;
            r_adj_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_adj_n     <= ~w_strobe;
            r_adj_pulse <= w_strobe;
        end
    end

    // A MODE press during auto-repeat parks the FSM in LOCK so that repeats never land
    // on the newly selected field; release wins over every other condition.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer + T_ONE;
        w_strobe     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_next = '0;
                if (w_adj_press) begin
                    if (w_mode_press) begin
                        w_state_next = ST_LOCK;
                    end else begin
                        w_strobe     = 1'b1;
                        w_state_next = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (!w_adj_held) begin
                    w_state_next = ST_IDLE;
                    w_timer_next = '0;
                end else if (w_mode_press) begin
                    w_state_next = ST_LOCK;
                    w_timer_next = '0;
                end else if (r_timer == RD_LAST) begin
                    w_strobe     = 1'b1;
                    w_timer_next = '0;
                    w_state_next = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                if (!w_adj_held) begin
                    w_state_next = ST_IDLE;
                    w_timer_next = '0;
                end else if (w_mode_press) begin
                    w_state_next = ST_LOCK;
                    w_timer_next = '0;
                end else if (r_timer == RP_LAST) begin
                    w_strobe     = 1'b1;
                    w_timer_next = '0;
                end
            end
            ST_LOCK: begin
                w_timer_next = '0;
                if (!w_adj_held) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    assign set          = r_set;
    assign adj_n        = r_adj_n;
    assign adj_pulse    = r_adj_pulse;
    assign mode_changed = r_mode_changed;

endmodule

// File: tb/tb_key_set_ctrl.sv
// Randomised scoreboard bench for key_set_ctrl: a cycle-level reference model of the
// key rules predicts every selector step and adjust strobe; a monitor pops and compares.
module tb_key_set_ctrl;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int NS = 3;

    typedef struct {
        int         cyc;
        bit         is_mode;
        logic [1:0] set;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode_n = 1'b0;
    logic       key_adj_n = 1'b0;
    logic [1:0] set;
    logic       adj_n;
    logic       adj_pulse;
    logic       mode_changed;

    key_set_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .NUM_SET        (NS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_mode_n  (key_mode_n),
        .key_adj_n   (key_adj_n),
        .set         (set),
        .adj_n       (adj_n),
        .adj_pulse   (adj_pulse),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    ev_t exp_q[$];
    int  dut_adj_cnt = 0;
    int  dut_mode_cnt = 0;

    // Reference model state: key index 0 = MODE, 1 = ADJ
    bit m_rst_edge = 1'b0;
    bit m_s1[2];
    bit m_s2[2];
    bit m_db[2];
    bit m_armed[2];
    bit pend1[2];
    bit pend2[2];
    int hi_run[2];
    int opp_run[2];
    int m_set = 0;
    bit adj_active = 1'b0;
    bit adj_locked = 1'b0;
    int t_first = 0;

    // Model: a key change is accepted after DB consecutive synchronised samples of the new
    // level; a press shows at the outputs two edges after acceptance. Strobes fall at fixed
    // offsets from the first one (0, RD, RD+k*RP) while ADJ stays held and MODE stays idle.
    always @(posedge clk) begin : model
        bit  mp;
        bit  ap;
        bit  held;
        bit  strobe;
        bit  raw;
        bit  s2;
        bit  pflag;
        int  dt;
        ev_t e;
        cyc++;
        m_rst_edge = rst;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_db[k] = 1'b1; m_armed[k] = 1'b0;
                pend1[k] = 1'b0; pend2[k] = 1'b0; hi_run[k] = 0; opp_run[k] = 0;
            end
            m_set = 0;
            adj_active = 1'b0;
            adj_locked = 1'b0;
        end else begin
            mp = pend2[0];
            ap = pend2[1];
            held = !m_db[1];
            strobe = 1'b0;
            if (adj_active) begin
                dt = cyc - t_first;
                if (!held) adj_active = 1'b0;
                else if (mp) begin adj_active = 1'b0; adj_locked = 1'b1; end
                else if (dt == RD || (dt > RD && (dt - RD) % RP == 0)) strobe = 1'b1;
            end else if (adj_locked) begin
                if (!held) adj_locked = 1'b0;
            end else if (ap) begin
                if (mp) adj_locked = 1'b1;
                else begin strobe = 1'b1; adj_active = 1'b1; t_first = cyc; end
            end
            if (mp) begin
                m_set = (m_set + 1) % NS;
                e.cyc = cyc; e.is_mode = 1'b1; e.set = 2'(m_set);
                exp_q.push_back(e);
            end
            if (strobe) begin
                e.cyc = cyc; e.is_mode = 1'b0; e.set = 2'(m_set);
                exp_q.push_back(e);
            end
            for (int k = 0; k < 2; k++) begin
                raw = (k == 0) ? key_mode_n : key_adj_n;
                s2 = m_s2[k];
                m_s2[k] = m_s1[k];
                m_s1[k] = raw;
                hi_run[k] = s2 ? hi_run[k] + 1 : 0;
                if (hi_run[k] >= DB + 2) m_armed[k] = 1'b1;
                opp_run[k] = (s2 != m_db[k]) ? opp_run[k] + 1 : 0;
                pflag = 1'b0;
                if (opp_run[k] == DB) begin
                    m_db[k] = s2;
                    opp_run[k] = 0;
                    pflag = m_armed[k] && !s2;
                end
                pend2[k] = pend1[k];
                pend1[k] = pflag;
            end
        end
    end

    always @(posedge clk) begin : monitor
        ev_t e;
        bit  ok;
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_cmp++; n_err++;
            $display("FAIL missing_event: cycle %0d expected %s set=%0d, DUT showed nothing",
                     e.cyc, e.is_mode ? "mode" : "adj", e.set);
        end
        if (m_rst_edge) begin
            n_cmp++;
            if (set !== 2'd0 || adj_n !== 1'b1 || adj_pulse !== 1'b0 || mode_changed !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs: cycle %0d got set=%0d adj_n=%b adj_pulse=%b mode_changed=%b, need 0/1/0/0",
                         cyc, set, adj_n, adj_pulse, mode_changed);
            end
        end else begin
            if (adj_pulse === 1'b1) dut_adj_cnt++;
            if (mode_changed === 1'b1) dut_mode_cnt++;
            if (adj_pulse !== 1'b0 || mode_changed !== 1'b0 || adj_n !== 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_output: cycle %0d adj_n=%b adj_pulse=%b mode_changed=%b, expected none",
                             cyc, adj_n, adj_pulse, mode_changed);
                end else begin
                    e = exp_q.pop_front();
                    ok = (e.cyc == cyc) && (mode_changed === e.is_mode) && (adj_pulse === !e.is_mode)
                         && (adj_n === !adj_pulse) && (set === e.set);
                    if (!ok) begin
                        n_err++;
                        $display("FAIL event: cycle %0d got mc=%b pulse=%b adj_n=%b set=%0d, need cycle %0d %s set=%0d",
                                 cyc, mode_changed, adj_pulse, adj_n, set, e.cyc,
                                 e.is_mode ? "mode" : "adj", e.set);
                    end else begin
                        $display("cycle %0d: %s set=%0d ok", cyc, e.is_mode ? "mode" : "adj", set);
                    end
                end
            end
            n_cmp++;
            if (set !== 2'(m_set)) begin
                n_err++;
                $display("FAIL set_track: cycle %0d got set=%0d need %0d", cyc, set, m_set);
            end
        end
    end

    task automatic drive(input bit m, input bit a, input int n);
        key_mode_n = m;
        key_adj_n  = a;
        repeat (n) @(negedge clk);
    endtask

    task automatic bounce(input bit m_end, input bit a_end, input bit on_m, input bit on_a);
        int segs;
        segs = $urandom_range(0, 3);
        for (int i = 0; i < segs; i++) begin
            drive(on_m ? !m_end : m_end, on_a ? !a_end : a_end, $urandom_range(1, DB - 1));
            drive(m_end, a_end, $urandom_range(1, DB - 1));
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d need %0d", name, got, want);
        end else begin
            $display("%s: %0d ok", name, got);
        end
    endtask

    initial begin : stim
        int a0;
        int m0;
        int op;
        // Reset with both keys held; they must not act until released and pressed again
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 30);
        drive(1, 1, 20);
        chk("held_through_reset_adj", dut_adj_cnt, 0);
        chk("held_through_reset_mode", dut_mode_cnt, 0);

        m0 = dut_mode_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 10);
            drive(1, 1, 10);
        end
        chk("three_mode_presses", dut_mode_cnt - m0, 3);
        chk("set_wraps_to_zero", int'(set), 0);
        chk("mode_no_adj", dut_adj_cnt, 0);

        a0 = dut_adj_cnt;
        drive(1, 0, 3);
        drive(1, 1, 10);
        chk("adj_glitch_rejected", dut_adj_cnt - a0, 0);
        drive(1, 0, 12);
        drive(1, 1, 20);
        chk("adj_single_strobe", dut_adj_cnt - a0, 1);

        a0 = dut_adj_cnt;
        drive(1, 0, 65);
        drive(1, 1, 20);
        chk("adj_repeat_count", dut_adj_cnt - a0, 7);

        m0 = dut_mode_cnt;
        drive(1, 0, 35);
        drive(0, 0, 10);
        a0 = dut_adj_cnt;
        drive(1, 0, 40);
        chk("lock_after_mode", dut_adj_cnt - a0, 0);
        chk("lock_mode_step", dut_mode_cnt - m0, 1);
        drive(1, 1, 20);
        a0 = dut_adj_cnt;
        drive(1, 0, 12);
        drive(1, 1, 20);
        chk("repress_after_lock", dut_adj_cnt - a0, 1);

        drive(1, 0, 37);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0 = dut_adj_cnt;
        drive(1, 0, 40);
        chk("held_after_midreset", dut_adj_cnt - a0, 0);
        chk("set_after_midreset", int'(set), 0);
        drive(1, 1, 20);

        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    bounce(0, 1, 1, 0);
                    drive(0, 1, $urandom_range(DB + 1, 14));
                    bounce(1, 1, 1, 0);
                    drive(1, 1, $urandom_range(DB + 4, 14));
                end
                1: begin
                    bounce(1, 0, 0, 1);
                    drive(1, 0, $urandom_range(5, 70));
                    bounce(1, 1, 0, 1);
                    drive(1, 1, $urandom_range(DB + 4, 16));
                end
                2: begin
                    drive(0, 0, $urandom_range(8, 40));
                    drive(1, 1, $urandom_range(DB + 4, 16));
                end
                3: begin
                    drive(1, 0, $urandom_range(10, 40));
                    drive(0, 0, $urandom_range(6, 12));
                    drive(1, 0, $urandom_range(1, 30));
                    drive(1, 1, $urandom_range(DB + 4, 16));
                end
                4: begin
                    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, DB - 1));
                    drive(1, 1, $urandom_range(1, 12));
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b1;
                        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
                        rst = 1'b0;
                    end
                    drive(1, 1, $urandom_range(DB + 4, 12));
                end
            endcase
        end

        drive(1, 1, 40);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
